// File: rtl/data_sram_slave.sv
// data_sram_slave
// Single-cycle SRAM-style slave with a word-addressed RAM and a small block of
// configuration registers (scratch, LEDs, synchronized switches, free-running
// timer with compare, and a sticky compare status flag).
//
// Ports:
//   clk             - single clock, all state updates on the rising edge
//   reset           - asynchronous, active-high reset
//   data_sram_en    - access request for the current cycle
//   data_sram_wen   - byte-lane write enables (all zero means read)
//   data_sram_addr  - byte address; addr[31:16]==CONF_HI selects the config block
//   data_sram_wdata - write data
//   data_sram_rdata - registered read data, valid one cycle after a read request
//   switch          - asynchronous board switches
//   led             - LED register
//   timer_irq       - sticky timer==compare flag
module data_sram_slave #(
    parameter int          ADDR_W  = 10,
    parameter logic [15:0] CONF_HI = 16'hBFAF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch,
    output logic [15:0] led,
    output logic        timer_irq
);

    localparam int RAM_WORDS = 1 << ADDR_W;

    // Word offsets (byte offset / 4) inside the config region
    localparam logic [13:0] OFF_SCRATCH = 14'h0;
    localparam logic [13:0] OFF_LED     = 14'h1;
    localparam logic [13:0] OFF_SWITCH  = 14'h2;
    localparam logic [13:0] OFF_TIMER   = 14'h3;
    localparam logic [13:0] OFF_CMP     = 14'h4;
    localparam logic [13:0] OFF_STATUS  = 14'h5;

    logic [31:0] mem [RAM_WORDS];

    logic [31:0] rdata_q,   rdata_d;
    logic [31:0] scratch_q, scratch_d;
    logic [15:0] led_q,     led_d;
    logic [7:0]  swMeta_q;
    logic [7:0]  swSync_q;
    logic [31:0] timer_q,   timer_d;
    logic [31:0] cmp_q,     cmp_d;
    logic        status_q,  status_d;

    logic              isConf;
    logic [13:0]       confOff;
    logic [ADDR_W-1:0] ramIdx;
    logic              doRead;
    logic              doWrite;
    logic              confWr;
    logic              ramWr;
    logic [31:0]       confRdata;
    logic              unusedAddrBits;

    // Byte-lane merge shared by every writable 32-bit register
    function automatic logic [31:0] laneMerge(input logic [31:0] oldVal,
                                              input logic [31:0] newVal,
                                              input logic [3:0]  laneEn);
        logic [31:0] res;
        res = oldVal;
        for (int i = 0; i < 4; i++) begin
            if (laneEn[i]) res[8*i +: 8] = newVal[8*i +: 8];
        end
        return res;
    endfunction

    // Region decode: everything outside the config window is RAM, with the
    // address bits above the word index ignored so the RAM aliases.
    assign isConf         = (data_sram_addr[31:16] == CONF_HI);
    assign confOff        = data_sram_addr[15:2];
    assign ramIdx         = data_sram_addr[ADDR_W+1:2];
    assign doRead         = data_sram_en && (data_sram_wen == 4'b0000);
    assign doWrite        = data_sram_en && (data_sram_wen != 4'b0000);
    assign confWr         = doWrite && isConf;
    assign ramWr          = doWrite && !isConf;
    assign unusedAddrBits = ^data_sram_addr[1:0];

    // RAM has no reset so it stays inferable as a plain synchronous array;
    // writes are held off while reset is asserted so no access completes.
    always_ff @(posedge clk) begin
        if (ramWr && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) mem[ramIdx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
        end
    end

    // Config read mux; the timer returns the value present in the read cycle
    always_comb begin
        confRdata = 32'h0;
        case (confOff)
            OFF_SCRATCH: confRdata = scratch_q;
            OFF_LED:     confRdata = {16'h0, led_q};
            OFF_SWITCH:  confRdata = {24'h0, swSync_q};
            OFF_TIMER:   confRdata = timer_q;
            OFF_CMP:     confRdata = cmp_q;
            OFF_STATUS:  confRdata = {31'h0, status_q};
            default:     confRdata = 32'h0;
        endcase
    end

    // Next-state for config registers and read data. A timer write overrides
    // the increment for that edge. The status flag is set whenever the timer
    // matches compare in this cycle, and that set beats a simultaneous clear.
    always_comb begin
        scratch_d = scratch_q;
        led_d     = led_q;
        timer_d   = timer_q + 32'd1;
        cmp_d     = cmp_q;
        status_d  = status_q;
        rdata_d   = rdata_q;

        if (confWr) begin
            case (confOff)
                OFF_SCRATCH: scratch_d = laneMerge(scratch_q, data_sram_wdata, data_sram_wen);
                OFF_LED: begin
                    if (data_sram_wen[0]) led_d[7:0]  = data_sram_wdata[7:0];
                    if (data_sram_wen[1]) led_d[15:8] = data_sram_wdata[15:8];
                end
                OFF_TIMER:   timer_d = laneMerge(timer_q, data_sram_wdata, data_sram_wen);
                OFF_CMP:     cmp_d   = laneMerge(cmp_q, data_sram_wdata, data_sram_wen);
                OFF_STATUS: begin
                    if (data_sram_wen[0] && data_sram_wdata[0]) status_d = 1'b0;
                end
                default: ;
            endcase
        end

        if (timer_q == cmp_q) status_d = 1'b1;

        if (doRead) rdata_d = isConf ? confRdata : mem[ramIdx];
    end

    // State registers; the switch inputs pass through a 2-flop synchronizer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q   <= 32'h0;
            scratch_q <= 32'h0;
            led_q     <= 16'h0;
            swMeta_q  <= 8'h0;
            swSync_q  <= 8'h0;
            timer_q   <= 32'h0;
            cmp_q     <= 32'hFFFF_FFFF;
            status_q  <= 1'b0;
        end else begin
            rdata_q   <= rdata_d;
            scratch_q <= scratch_d;
            led_q     <= led_d;
            swMeta_q  <= switch;
            swSync_q  <= swMeta_q;
            timer_q   <= timer_d;
            cmp_q     <= cmp_d;
            status_q  <= status_d;
        end
    end

    assign data_sram_rdata = rdata_q;
    assign led             = led_q;
    assign timer_irq       = status_q;

endmodule

// File: tb/tb_data_sram_slave.sv
// tb_data_sram_slave
// Self-checking bench for data_sram_slave: directed scenarios for reset, RAM
// byte lanes and aliasing, LED, switch synchronizer, timer/compare/status and
// asynchronous reset mid-access, plus randomized RAM traffic checked against
// an array model of the memory.
module tb_data_sram_slave;

    localparam int          ADDR_W    = 10;
    localparam logic [15:0] CONF_HI   = 16'hBFAF;
    localparam logic [31:0] A_SCRATCH = 32'hBFAF0000;
    localparam logic [31:0] A_LED     = 32'hBFAF0004;
    localparam logic [31:0] A_SWITCH  = 32'hBFAF0008;
    localparam logic [31:0] A_TIMER   = 32'hBFAF000C;
    localparam logic [31:0] A_CMP     = 32'hBFAF0010;
    localparam logic [31:0] A_STATUS  = 32'hBFAF0014;

    logic        clk;
    logic        reset;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  sw;
    logic [15:0] led;
    logic        irq;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] expRd;
    logic [31:0] ramModel [16];
    int          slotIdx  [16];
    logic [31:0] scratchModel;

    data_sram_slave #(.ADDR_W(ADDR_W), .CONF_HI(CONF_HI)) dut (
        .clk             (clk),
        .reset           (reset),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .switch          (sw),
        .led             (led),
        .timer_irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-masked update: lanes with wen set take the new data
    function automatic logic [31:0] byteMerge(input logic [31:0] oldVal,
                                              input logic [31:0] newVal,
                                              input logic [3:0]  w);
        logic [31:0] mask;
        mask = {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
        return (oldVal & ~mask) | (newVal & mask);
    endfunction

    // RAM byte address for a word index with random aliasing bits above it
    function automatic logic [31:0] mkAddr(input int idx);
        logic [15:0] hi;
        hi = 16'($urandom);
        if (hi == CONF_HI) hi = ~hi;
        return {hi, 4'($urandom), 10'(idx), 2'($urandom)};
    endfunction

    // Present one cycle of inputs, let the edge happen, sample 1 ns later
    task automatic drive(input logic e, input logic [3:0] w,
                         input logic [31:0] a, input logic [31:0] d);
        en    = e;
        wen   = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
    endtask

    // en=0 cycle with junk on every other input
    task automatic idle();
        drive(1'b0, 4'($urandom_range(1, 15)), $urandom, $urandom);
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0; sw = 8'h00;
        #2 reset = 1'b1;
        #1;
        tests++; if (rdata !== 32'h0) begin fails++; $display("[TB] FAIL reset_rdata: got %h want %h", rdata, 32'h0); end
        tests++; if (led !== 16'h0) begin fails++; $display("[TB] FAIL reset_led: got %h want %h", led, 16'h0); end
        tests++; if (irq !== 1'b0) begin fails++; $display("[TB] FAIL reset_irq: got %b want 0", irq); end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        drive(1'b1, 4'h0, A_TIMER, 32'h0);
        tests++; if (rdata !== 32'h0) begin fails++; $display("[TB] FAIL timer_first_cycle: got %h want %h", rdata, 32'h0); end
        drive(1'b1, 4'h0, A_CMP, 32'h0);
        tests++; if (rdata !== 32'hFFFF_FFFF) begin fails++; $display("[TB] FAIL cmp_reset: got %h want %h", rdata, 32'hFFFF_FFFF); end
        drive(1'b1, 4'h0, A_STATUS, 32'h0);
        tests++; if (rdata !== 32'h0) begin fails++; $display("[TB] FAIL status_reset: got %h want %h", rdata, 32'h0); end
        drive(1'b1, 4'h0, A_SCRATCH, 32'h0);
        tests++; if (rdata !== 32'h0) begin fails++; $display("[TB] FAIL scratch_reset: got %h want %h", rdata, 32'h0); end
        // Four edges have passed since release, so the timer holds 4 now
        drive(1'b1, 4'h0, A_TIMER, 32'h0);
        tests++; if (rdata !== 32'd4) begin fails++; $display("[TB] FAIL timer_count: got %h want %h", rdata, 32'd4); end
        expRd = 32'd4;
    endtask

    task automatic test_ram_basic();
        drive(1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
        tests++; if (rdata !== expRd) begin fails++; $display("[TB] FAIL write_holds_rdata: got %h want %h", rdata, expRd); end
        drive(1'b1, 4'h0, 32'h0000_0010, 32'h0);
        expRd = 32'hDEAD_BEEF;
        tests++; if (rdata !== expRd) begin fails++; $display("[TB] FAIL ram_rd_after_wr: got %h want %h", rdata, expRd); end
        idle();
        tests++; if (rdata !== expRd) begin fails++; $display("[TB] FAIL idle_holds_rdata: got %h want %h", rdata, expRd); end
        drive(1'b1, 4'b0010, 32'h0000_0010, 32'h0000_AA00);
        drive(1'b1, 4'h0, 32'h0000_0010, 32'h0);
        expRd = 32'hDEAD_AAEF;
        tests++; if (rdata !== expRd) begin fails++; $display("[TB] FAIL ram_lane1: got %h want %h", rdata, expRd); end
        drive(1'b1, 4'h0, 32'h0000_1010, 32'h0);
        tests++; if (rdata !== expRd) begin fails++; $display("[TB] FAIL ram_alias: got %h want %h", rdata, expRd); end
    endtask

    task automatic test_ram_random();
        int          k;
        int          op;
        logic [3:0]  w;
        logic [31:0] d;
        logic [31:0] a;
        for (int i = 0; i < 16; i++) begin
            slotIdx[i]  = 100 + 37 * i;
            ramModel[i] = $urandom;
            drive(1'b1, 4'hF, mkAddr(slotIdx[i]), ramModel[i]);
        end
        tests++; if (rdata !== expRd) begin fails++; $display("[TB] FAIL rand_init_hold: got %h want %h", rdata, expRd); end
        for (int n = 0; n < 200; n++) begin
            k  = $urandom_range(0, 15);
            op = $urandom_range(0, 3);
            a  = mkAddr(slotIdx[k]);
            d  = $urandom;
            if (op == 0) begin
                drive(1'b0, 4'($urandom_range(1, 15)), a, d);
                tests++; if (rdata !== expRd) begin fails++; $display("[TB] FAIL rand_idle n=%0d: got %h want %h", n, rdata, expRd); end
            end else if (op == 1) begin
                w           = 4'($urandom_range(1, 15));
                ramModel[k] = byteMerge(ramModel[k], d, w);
                drive(1'b1, w, a, d);
                tests++; if (rdata !== expRd) begin fails++; $display("[TB] FAIL rand_wr_hold n=%0d: got %h want %h", n, rdata, expRd); end
            end else begin
                drive(1'b1, 4'h0, a, d);
                expRd = ramModel[k];
                tests++; if (rdata !== expRd) begin fails++; $display("[TB] FAIL rand_rd n=%0d addr=%h: got %h want %h", n, a, rdata, expRd); end
            end
        end
    endtask

    task automatic test_scratch_lanes();
        logic [3:0]  w;
        logic [31:0] d;
        scratchModel = 32'h0;
        for (int n = 0; n < 10; n++) begin
            w            = 4'($urandom_range(1, 15));
            d            = $urandom;
            scratchModel = byteMerge(scratchModel, d, w);
            drive(1'b1, w, A_SCRATCH, d);
            drive(1'b1, 4'h0, A_SCRATCH, 32'h0);
            expRd = scratchModel;
            tests++; if (rdata !== expRd) begin fails++; $display("[TB] FAIL scratch n=%0d: got %h want %h", n, rdata, expRd); end
        end
    endtask

    task automatic test_led();
        drive(1'b1, 4'hF, A_LED, 32'h1234_ABCD);
        tests++; if (led !== 16'hABCD) begin fails++; $display("[TB] FAIL led_write: got %h want %h", led, 16'hABCD); end
        drive(1'b1, 4'h0, A_LED, 32'h0);
        expRd = 32'h0000_ABCD;
        tests++; if (rdata !== expRd) begin fails++; $display("[TB] FAIL led_read: got %h want %h", rdata, expRd); end
        drive(1'b1, 4'b1100, A_LED, 32'hFFFF_FFFF);
        tests++; if (led !== 16'hABCD) begin fails++; $display("[TB] FAIL led_upper_lanes: got %h want %h", led, 16'hABCD); end
        drive(1'b1, 4'b0001, A_LED, 32'h0000_0012);
        drive(1'b1, 4'h0, A_LED, 32'h0);
        expRd = 32'h0000_AB12;
        tests++; if (rdata !== expRd) begin fails++; $display("[TB] FAIL led_lane0: got %h want %h", rdata, expRd); end
    endtask

    task automatic test_switch();
        sw = 8'hA5;
        repeat (3) idle();
        drive(1'b1, 4'h0, A_SWITCH, 32'h0);
        expRd = 32'h0000_00A5;
        tests++; if (rdata !== expRd) begin fails++; $display("[TB] FAIL switch_read: got %h want %h", rdata, expRd); end
        drive(1'b1, 4'hF, A_SWITCH, 32'hFFFF_FFFF);
        drive(1'b1, 4'h0, A_SWITCH, 32'h0);
        tests++; if (rdata !== expRd) begin fails++; $display("[TB] FAIL switch_ro: got %h want %h", rdata, expRd); end
        // Two synchronizer stages: the new value reaches rdata on the third read
        sw = 8'h3C;
        drive(1'b1, 4'h0, A_SWITCH, 32'h0);
        tests++; if (rdata !== 32'h0000_00A5) begin fails++; $display("[TB] FAIL switch_sync1: got %h want %h", rdata, 32'h0000_00A5); end
        drive(1'b1, 4'h0, A_SWITCH, 32'h0);
        tests++; if (rdata !== 32'h0000_00A5) begin fails++; $display("[TB] FAIL switch_sync2: got %h want %h", rdata, 32'h0000_00A5); end
        drive(1'b1, 4'h0, A_SWITCH, 32'h0);
        expRd = 32'h0000_003C;
        tests++; if (rdata !== expRd) begin fails++; $display("[TB] FAIL switch_sync3: got %h want %h", rdata, expRd); end
    endtask

    task automatic test_timer();
        drive(1'b1, 4'hF, A_TIMER, 32'hFFFF_FFFE);
        drive(1'b1, 4'hF, A_CMP, 32'h0000_0001);
        drive(1'b1, 4'h0, A_TIMER, 32'h0);
        tests++; if (rdata !== 32'hFFFF_FFFF) begin fails++; $display("[TB] FAIL timer_ffffffff: got %h want %h", rdata, 32'hFFFF_FFFF); end
        drive(1'b1, 4'h0, A_TIMER, 32'h0);
        tests++; if (rdata !== 32'h0) begin fails++; $display("[TB] FAIL timer_wrap: got %h want %h", rdata, 32'h0); end
        tests++; if (irq !== 1'b0) begin fails++; $display("[TB] FAIL irq_early: got %b want 0", irq); end
        idle();
        tests++; if (irq !== 1'b1) begin fails++; $display("[TB] FAIL irq_set: got %b want 1", irq); end
        drive(1'b1, 4'h0, A_STATUS, 32'h0);
        tests++; if (rdata !== 32'h1) begin fails++; $display("[TB] FAIL status_read: got %h want %h", rdata, 32'h1); end
        drive(1'b1, 4'b0001, A_STATUS, 32'h1);
        tests++; if (irq !== 1'b0) begin fails++; $display("[TB] FAIL irq_clear: got %b want 0", irq); end
        drive(1'b1, 4'hF, A_TIMER, 32'h0000_1000);
        drive(1'b1, 4'hF, A_CMP, 32'h0000_1001);
        tests++; if (irq !== 1'b0) begin fails++; $display("[TB] FAIL irq_no_match: got %b want 0", irq); end
        // Timer equals compare in this cycle: the set must beat the clear
        drive(1'b1, 4'b0001, A_STATUS, 32'h1);
        tests++; if (irq !== 1'b1) begin fails++; $display("[TB] FAIL irq_set_wins: got %b want 1", irq); end
        idle();
        tests++; if (irq !== 1'b1) begin fails++; $display("[TB] FAIL irq_sticky: got %b want 1", irq); end
        // Timer is 0x1003 here; a lane-1 write loads 0x0000AB03
        drive(1'b1, 4'b0010, A_TIMER, 32'h0000_AB00);
        drive(1'b1, 4'h0, A_TIMER, 32'h0);
        expRd = 32'h0000_AB03;
        tests++; if (rdata !== expRd) begin fails++; $display("[TB] FAIL timer_lane_load: got %h want %h", rdata, expRd); end
        drive(1'b1, 4'b0001, A_STATUS, 32'h1);
        tests++; if (irq !== 1'b0) begin fails++; $display("[TB] FAIL irq_clear2: got %b want 0", irq); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 4'hF, A_TIMER, 32'h0000_0020);
        drive(1'b1, 4'hF, A_CMP, 32'h0000_0021);
        idle();
        tests++; if (irq !== 1'b1) begin fails++; $display("[TB] FAIL irq_before_reset: got %b want 1", irq); end
        drive(1'b1, 4'hF, A_SCRATCH, 32'h0000_0055);
        drive(1'b1, 4'h0, A_SCRATCH, 32'h0);
        tests++; if (rdata !== 32'h55) begin fails++; $display("[TB] FAIL scratch_55: got %h want %h", rdata, 32'h55); end
        en = 1'b1; wen = 4'h0; addr = A_SCRATCH;
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests++; if (rdata !== 32'h0) begin fails++; $display("[TB] FAIL async_rdata: got %h want %h", rdata, 32'h0); end
        tests++; if (led !== 16'h0) begin fails++; $display("[TB] FAIL async_led: got %h want %h", led, 16'h0); end
        tests++; if (irq !== 1'b0) begin fails++; $display("[TB] FAIL async_irq: got %b want 0", irq); end
        @(posedge clk);
        #1;
        tests++; if (rdata !== 32'h0) begin fails++; $display("[TB] FAIL aborted_read: got %h want %h", rdata, 32'h0); end
        en = 1'b0;
        reset = 1'b0;
        drive(1'b1, 4'h0, A_CMP, 32'h0);
        tests++; if (rdata !== 32'hFFFF_FFFF) begin fails++; $display("[TB] FAIL cmp_after_reset: got %h want %h", rdata, 32'hFFFF_FFFF); end
        drive(1'b1, 4'h0, A_SCRATCH, 32'h0);
        tests++; if (rdata !== 32'h0) begin fails++; $display("[TB] FAIL scratch_after_reset: got %h want %h", rdata, 32'h0); end
        drive(1'b1, 4'h0, 32'h0000_0010, 32'h0);
        tests++; if (rdata !== 32'hDEAD_AAEF) begin fails++; $display("[TB] FAIL ram_kept: got %h want %h", rdata, 32'hDEAD_AAEF); end
    endtask

    initial begin
        test_reset();
        test_ram_basic();
        test_ram_random();
        test_scratch_lanes();
        test_led();
        test_switch();
        test_timer();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/data_sram_slave.md
DATA_SRAM_SLAVE -- requirements
Module: data_sram_slave

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning the RAM word-index width (2^ADDR_W 32-bit words).
REQ-002 The block SHALL have parameter CONF_HI, default 16'hBFAF, meaning the addr[31:16] value that selects the config-register region.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, meaning the reset, which is asynchronous and active-high.
REQ-005 The block SHALL have port data_sram_en, input, 1, meaning the access request for this cycle.
REQ-006 The block SHALL have port data_sram_wen, input, 4, meaning the byte-lane write enables, where 0 denotes a read.
REQ-007 The block SHALL have port data_sram_addr, input, 32, meaning the byte address.
REQ-008 The block SHALL have port data_sram_wdata, input, 32, meaning the write data.
REQ-009 The block SHALL have port data_sram_rdata, output, 32, meaning the registered read data.
REQ-010 The block SHALL have port switch, input, 8, meaning the asynchronous board switches.
REQ-011 The block SHALL have port led, output, 16, meaning the LED register.
REQ-012 The block SHALL have port timer_irq, output, 1, meaning the sticky timer-compare flag.

Function
REQ-013 The block SHALL decode the region as follows: addr[31:16]==CONF_HI selects confreg; any other address selects RAM at word index addr[ADDR_W+1:2], with higher bits ignored (aliasing) and addr[1:0] ignored.
REQ-014 The block SHALL treat en=1 with wen=0 in cycle N as a read, driving the data on rdata from the rising edge ending cycle N (one-cycle latency), with no wait states.
REQ-015 The block SHALL, on en=1 with wen!=0, write wdata[8i+7:8i] into lane i only where wen[i]=1 at the clock edge, leaving the other lanes unchanged.
REQ-016 The block SHALL hold rdata unchanged on write cycles and on en=0 cycles.
REQ-017 The block SHALL return the newly written data when a write to address A in cycle N is followed by a read of A in cycle N+1.
REQ-018 The block SHALL implement confreg offset 0x00 as SCRATCH: 32-bit, read/write, with byte lanes.
REQ-019 The block SHALL implement confreg offset 0x04 as LED: bits[15:0] read/write with lanes 0-1 and drive the led port; bits[31:16] SHALL read 0.
REQ-020 The block SHALL implement confreg offset 0x08 as SWITCH: read-only, returning {24'b0, sw_sync}, where sw_sync is switch passed through a 2-flop synchronizer; writes are ignored.
REQ-021 The block SHALL implement confreg offset 0x0C as TIMER: a 32-bit free-running counter that increments by 1 every cycle and wraps from FFFFFFFF to 0.
REQ-022 The block SHALL, on a TIMER write, load the lane-merged value, with the write taking priority over the increment for that edge and counting resuming from the loaded value on the next edge.
REQ-023 The block SHALL return, on a TIMER read, the counter value present during the read cycle.
REQ-024 The block SHALL implement confreg offset 0x10 as CMP: 32-bit, read/write, with byte lanes.
REQ-025 The block SHALL implement confreg offset 0x14 as STATUS: bit0 is set at the edge ending any cycle with TIMER==CMP, and writing 1 to bit0 (wen[0]=1) clears it; set wins when both occur in the same cycle; bits[31:1] read 0.
REQ-026 The block SHALL drive timer_irq equal to STATUS bit0.
REQ-027 The block SHALL return 0 on reads of any other confreg offset and ignore writes to them.
REQ-028 The block SHALL NOT reset RAM contents; RAM is implemented as an inferable synchronous array.

Reset
REQ-029 The block SHALL, while reset=1, immediately force rdata=0, led=0, SCRATCH=0, TIMER=0, CMP=FFFFFFFF, STATUS=0, timer_irq=0, and synchronizer flops=0, independent of clk.
REQ-030 The block SHALL, after reset deasserts, begin updating any state only at the first subsequent clk rising edge, with TIMER reading 0 in that first cycle.
REQ-031 The block SHALL NOT complete an access when reset is asserted mid-access (between request and rdata); that rdata SHALL read 0.

Verification
REQ-032 The bench SHALL cover: write addr 0x00000010 data 0xDEADBEEF wen=F, then read same address next cycle -> rdata=0xDEADBEEF one cycle after the read.
REQ-033 The bench SHALL cover: after REQ-032, write wen=4'b0010 data 0x0000AA00, then read -> rdata=0xDEADAAEF; read of 0x00001010 (ADDR_W=10 alias) -> same value.
REQ-034 The bench SHALL cover: write 0xBFAF0004 data 0x1234ABCD wen=F -> led=0xABCD next cycle; read -> rdata=0x0000ABCD.
REQ-035 The bench SHALL cover: switch=0xA5 held 3 cycles, read 0xBFAF0008 -> rdata=0x000000A5; write to it -> no change.
REQ-036 The bench SHALL cover: write TIMER=FFFFFFFE, CMP=0x00000001 -> TIMER wraps to 0 two cycles later, timer_irq=1 after TIMER==1; write 1 to STATUS while TIMER!=CMP -> timer_irq=0 next cycle; clear in a match cycle -> stays 1.
REQ-037 The bench SHALL cover: assert reset asynchronously mid-read of SCRATCH=0x55 -> rdata=0, led=0, timer_irq=0 without a clock edge; CMP reads FFFFFFFF after release.
